// File: rtl/instruction_loader_if.sv
// Stream-in / memory-write bundle for instruction_loader.
// The loader connects via slave; the host/receiver side uses master.
interface instruction_loader_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              i_start;
    logic [7:0]        i_rx_data;
    logic              i_rx_valid;
    logic              o_rx_ready;
    logic              o_mem_wr_en;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_data;
    logic              o_busy;
    logic              o_done;
    logic              o_overflow;
    logic [ADDR_W:0]   o_word_count;

    modport master (
        output i_start, i_rx_data, i_rx_valid,
        input  o_rx_ready, o_mem_wr_en, o_mem_addr, o_mem_data,
               o_busy, o_done, o_overflow, o_word_count
    );

    modport slave (
        input  i_start, i_rx_data, i_rx_valid,
        output o_rx_ready, o_mem_wr_en, o_mem_addr, o_mem_data,
               o_busy, o_done, o_overflow, o_word_count
    );
endinterface

// File: rtl/instruction_loader.sv
// Packs a byte stream (MSB first) into 32-bit words and writes them to
// consecutive instruction-memory addresses from 0 until the HALT word is written.
module instruction_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    instruction_loader_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        DONE,
        ERROR
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_t            state, next_state;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        byte_cnt;
    logic [31:0]       shreg;
    logic [ADDR_W:0]   word_count;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [31:0]       mem_data_r;

    logic rx_ready;
    logic wr_en;
    logic busy;
    logic done;
    logic overflow;
    logic xfer;

    assign xfer = bus.i_rx_valid && rx_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERROR: begin
                if (bus.i_start) begin
                    next_state = RECV;
                end
            end
            RECV: begin
                if (xfer && byte_cnt == 2'd3) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                if (shreg == HALT_WORD) begin
                    next_state = DONE;
                end else if (addr == ADDR_MAX) begin
                    next_state = ERROR;
                end else begin
                    next_state = RECV;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        rx_ready = 1'b0;
        wr_en    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        overflow = 1'b0;
        case (state)
            RECV: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
            WRITE: begin
                wr_en = 1'b1;
                busy  = 1'b1;
            end
            DONE:    done     = 1'b1;
            ERROR:   overflow = 1'b1;
            default: ;
        endcase
    end

    // Write address/data are captured on the 4th byte so they hold steady
    // after the strobe while addr and shreg move on to the next word.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr       <= '0;
            byte_cnt   <= '0;
            shreg      <= '0;
            word_count <= '0;
            mem_addr_r <= '0;
            mem_data_r <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (bus.i_start) begin
                        addr       <= '0;
                        byte_cnt   <= '0;
                        word_count <= '0;
                    end
                end
                RECV: begin
                    if (xfer) begin
                        shreg <= {shreg[23:0], bus.i_rx_data};
                        if (byte_cnt == 2'd3) begin
                            byte_cnt   <= '0;
                            mem_addr_r <= addr;
                            mem_data_r <= {shreg[23:0], bus.i_rx_data};
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
                WRITE: begin
                    word_count <= word_count + {{ADDR_W{1'b0}}, 1'b1};
                    if (shreg != HALT_WORD && addr != ADDR_MAX) begin
                        addr <= addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_rx_ready   = rx_ready;
    assign bus.o_mem_wr_en  = wr_en;
    assign bus.o_mem_addr   = mem_addr_r;
    assign bus.o_mem_data   = mem_data_r;
    assign bus.o_busy       = busy;
    assign bus.o_done       = done;
    assign bus.o_overflow   = overflow;
    assign bus.o_word_count = word_count;
endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: one ADDR_W=8 instance for the main
// load flows and one ADDR_W=2 instance for memory-full / last-address cases.
module tb_instruction_loader;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       sel = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned cyc = 0;

    instruction_loader_if #(.ADDR_W(8)) if8 ();
    instruction_loader_if #(.ADDR_W(2)) if2 ();

    instruction_loader #(.ADDR_W(8), .HALT_WORD(32'hFFFF_FFFF)) dut8 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (if8.slave)
    );

    instruction_loader #(.ADDR_W(2), .HALT_WORD(32'hFFFF_FFFF)) dut2 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (if2.slave)
    );

    assign if8.i_start    = start & ~sel;
    assign if8.i_rx_valid = rx_valid & ~sel;
    assign if8.i_rx_data  = rx_data;
    assign if2.i_start    = start & sel;
    assign if2.i_rx_valid = rx_valid & sel;
    assign if2.i_rx_data  = rx_data;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        int unsigned cyc;
        int unsigned hs;
    } wr_t;

    wr_t         q8[$];
    wr_t         q2[$];
    int unsigned hs8 = 0, hs2 = 0, dbl = 0;
    logic        prev8 = 1'b0, prev2 = 1'b0;

    // hs holds the cycle index of the most recent byte transfer edge
    always @(negedge clk) begin
        if (if8.i_rx_valid && if8.o_rx_ready) hs8 = cyc + 1;
        if (if2.i_rx_valid && if2.o_rx_ready) hs2 = cyc + 1;
        if (if8.o_mem_wr_en) begin
            if (prev8) dbl++;
            q8.push_back('{addr: if8.o_mem_addr, data: if8.o_mem_data, cyc: cyc, hs: hs8});
        end
        if (if2.o_mem_wr_en) begin
            if (prev2) dbl++;
            q2.push_back('{addr: {6'b0, if2.o_mem_addr}, data: if2.o_mem_data, cyc: cyc, hs: hs2});
        end
        prev8 = if8.o_mem_wr_en;
        prev2 = if2.o_mem_wr_en;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        int unsigned tmo = 0;
        rx_valid = 1'b0;
        repeat (gap) tick();
        rx_data  = b;
        rx_valid = 1'b1;
        while (!(sel ? if2.o_rx_ready : if8.o_rx_ready) && tmo < 20) begin
            tick();
            tmo++;
        end
        if (!(sel ? if2.o_rx_ready : if8.o_rx_ready)) check("rx_ready_timeout", 32'd0, 32'd1);
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int unsigned gap);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], gap);
    endtask

    task automatic expect_write(input logic s, input int unsigned idx,
                                input logic [7:0] ea, input logic [31:0] ed);
        int unsigned tmo = 0;
        wr_t w;
        while ((s ? q2.size() : q8.size()) <= idx && tmo < 12) begin
            tick();
            tmo++;
        end
        if ((s ? q2.size() : q8.size()) <= idx) begin
            check("write_timeout", 32'd0, 32'd1);
            return;
        end
        w = s ? q2[idx] : q8[idx];
        check("wr_addr", {24'b0, w.addr}, {24'b0, ea});
        check("wr_data", w.data, ed);
        check("wr_latency", w.cyc, w.hs);
    endtask

    typedef struct {
        logic        start;
        logic [31:0] word;
        int unsigned gap;
        logic [7:0]  exp_addr;
        logic        exp_done;
        logic [8:0]  exp_cnt;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{start: 1'b1, word: 32'h2001_0005, gap: 0, exp_addr: 8'd0, exp_done: 1'b0, exp_cnt: 9'd1};
        vecs[1] = '{start: 1'b0, word: 32'hFFFF_FFFF, gap: 0, exp_addr: 8'd1, exp_done: 1'b1, exp_cnt: 9'd2};
        vecs[2] = '{start: 1'b1, word: 32'h2001_0005, gap: 3, exp_addr: 8'd0, exp_done: 1'b0, exp_cnt: 9'd1};
        vecs[3] = '{start: 1'b0, word: 32'hFFFF_FFFF, gap: 3, exp_addr: 8'd1, exp_done: 1'b1, exp_cnt: 9'd2};

        // Reset state
        repeat (3) tick();
        check("rst_rx_ready", {31'b0, if8.o_rx_ready}, 32'd0);
        check("rst_busy", {31'b0, if8.o_busy}, 32'd0);
        check("rst_done", {31'b0, if8.o_done}, 32'd0);
        check("rst_overflow", {31'b0, if8.o_overflow}, 32'd0);
        check("rst_wr_en", {31'b0, if8.o_mem_wr_en}, 32'd0);
        check("rst_word_count", {23'b0, if8.o_word_count}, 32'd0);
        rst = 1'b0;
        tick();

        // Byte offered while idle is neither accepted nor consumed
        rx_data  = 8'hAA;
        rx_valid = 1'b1;
        repeat (3) tick();
        check("idle_rx_ready", {31'b0, if8.o_rx_ready}, 32'd0);
        check("idle_busy", {31'b0, if8.o_busy}, 32'd0);
        check("idle_no_write", q8.size(), 32'd0);
        rx_valid = 1'b0;
        tick();

        // Back-to-back and gapped streams, both ending with HALT
        for (int i = 0; i < 4; i++) begin
            if (vecs[i].start) begin
                q8.delete();
                pulse_start();
                check("start_busy", {31'b0, if8.o_busy}, 32'd1);
                check("start_done_clr", {31'b0, if8.o_done}, 32'd0);
            end
            send_word(vecs[i].word, vecs[i].gap);
            expect_write(1'b0, {31'b0, vecs[i].exp_done}, vecs[i].exp_addr, vecs[i].word);
            check("vec_done", {31'b0, if8.o_done}, {31'b0, vecs[i].exp_done});
            check("vec_busy", {31'b0, if8.o_busy}, {31'b0, ~vecs[i].exp_done});
            check("vec_overflow", {31'b0, if8.o_overflow}, 32'd0);
            check("vec_word_count", {23'b0, if8.o_word_count}, {23'b0, vecs[i].exp_cnt});
        end
        check("hold_addr", {24'b0, if8.o_mem_addr}, 32'd1);
        check("hold_data", if8.o_mem_data, 32'hFFFF_FFFF);

        // Start pulse mid-word is ignored; restart after DONE goes back to addr 0
        q8.delete();
        pulse_start();
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        pulse_start();
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        expect_write(1'b0, 0, 8'd0, 32'h1122_3344);
        send_word(32'hFFFF_FFFF, 0);
        expect_write(1'b0, 1, 8'd1, 32'hFFFF_FFFF);
        check("mid_start_done", {31'b0, if8.o_done}, 32'd1);
        check("mid_start_count", {23'b0, if8.o_word_count}, 32'd2);
        q8.delete();
        pulse_start();
        check("restart_done_clr", {31'b0, if8.o_done}, 32'd0);
        check("restart_count_clr", {23'b0, if8.o_word_count}, 32'd0);
        send_word(32'h1234_5678, 0);
        expect_write(1'b0, 0, 8'd0, 32'h1234_5678);

        // Asynchronous reset after two bytes of a word
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        q8.delete();
        rst = 1'b1;
        #1;
        check("arst_busy", {31'b0, if8.o_busy}, 32'd0);
        check("arst_rx_ready", {31'b0, if8.o_rx_ready}, 32'd0);
        check("arst_addr", {24'b0, if8.o_mem_addr}, 32'd0);
        check("arst_data", if8.o_mem_data, 32'd0);
        check("arst_word_count", {23'b0, if8.o_word_count}, 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("arst_no_write", q8.size(), 32'd0);
        pulse_start();
        send_word(32'hCAFE_BABE, 0);
        expect_write(1'b0, 0, 8'd0, 32'hCAFE_BABE);
        send_word(32'hFFFF_FFFF, 0);
        expect_write(1'b0, 1, 8'd1, 32'hFFFF_FFFF);
        check("arst_done", {31'b0, if8.o_done}, 32'd1);

        // Small memory: fill without HALT, then HALT landing on the last address
        sel = 1'b1;
        q2.delete();
        pulse_start();
        for (int w = 0; w < 4; w++) begin
            send_word(32'(w + 1), 0);
            expect_write(1'b1, w, 8'(w), 32'(w + 1));
        end
        check("ovf_overflow", {31'b0, if2.o_overflow}, 32'd1);
        check("ovf_done", {31'b0, if2.o_done}, 32'd0);
        check("ovf_rx_ready", {31'b0, if2.o_rx_ready}, 32'd0);
        check("ovf_word_count", {29'b0, if2.o_word_count}, 32'd4);
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        repeat (8) tick();
        rx_valid = 1'b0;
        check("ovf_no_5th_write", q2.size(), 32'd4);
        check("ovf_hold", {31'b0, if2.o_overflow}, 32'd1);

        q2.delete();
        pulse_start();
        check("ovf_restart_clr", {31'b0, if2.o_overflow}, 32'd0);
        for (int w = 0; w < 3; w++) begin
            send_word(32'hA0 + 32'(w), 0);
            expect_write(1'b1, w, 8'(w), 32'hA0 + 32'(w));
        end
        send_word(32'hFFFF_FFFF, 0);
        expect_write(1'b1, 3, 8'd3, 32'hFFFF_FFFF);
        check("last_halt_done", {31'b0, if2.o_done}, 32'd1);
        check("last_halt_overflow", {31'b0, if2.o_overflow}, 32'd0);
        check("last_halt_count", {29'b0, if2.o_word_count}, 32'd4);

        check("wr_pulse_width", dbl, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
